// File: rtl/sram_ctrl_pkg.sv
// rtl/sram_ctrl_pkg.sv - shared widths, port-0 state encoding and miss data for wb_sram_ctrl
package sram_ctrl_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 8;

  localparam logic [31:0] MISS_DATA = 32'h0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RDWAIT = 2'd1,
    ACK    = 2'd2
  } p0_state_e;

endpackage

// File: rtl/stream_fifo2.sv
// rtl/stream_fifo2.sv - two-entry FIFO with occupancy output for the port-1 stream
module stream_fifo2 #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         valid,
  output logic [1:0]   occupancy
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;
  logic         push_ok;
  logic         pop_ok;

  assign pop_ok  = pop & (count != 2'd0);
  assign push_ok = push & ((count != 2'd2) | pop_ok);

  assign pop_data  = mem[rd_ptr];
  assign valid     = (count != 2'd0);
  assign occupancy = count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop_ok) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wb_sram_ctrl.sv
// rtl/wb_sram_ctrl.sv - Wishbone slave on port 0 and burst stream reader on port 1 of the 1RW1R SRAM macro
module wb_sram_ctrl #(
  parameter int          DATA_W    = sram_ctrl_pkg::DATA_W,
  parameter int          ADDR_W    = sram_ctrl_pkg::ADDR_W,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_dat_i,
  input  logic [31:0]       wbs_adr_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  output logic              sram_csb0,
  output logic              sram_web0,
  output logic [3:0]        sram_wmask0,
  output logic [ADDR_W-1:0] sram_addr0,
  output logic [DATA_W-1:0] sram_din0,
  input  logic [DATA_W-1:0] sram_dout0,
  output logic              sram_csb1,
  output logic [ADDR_W-1:0] sram_addr1,
  input  logic [DATA_W-1:0] sram_dout1,
  input  logic              rd_start,
  input  logic [ADDR_W-1:0] rd_base,
  input  logic [ADDR_W:0]   rd_len,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              rd_busy
);

  import sram_ctrl_pkg::p0_state_e;
  import sram_ctrl_pkg::IDLE;
  import sram_ctrl_pkg::RDWAIT;
  import sram_ctrl_pkg::ACK;
  import sram_ctrl_pkg::MISS_DATA;

  localparam logic [ADDR_W:0] LEN_ONE = 1;

  // ---------------- port 0: Wishbone ----------------
  p0_state_e p0_state;
  logic      req;
  logic      hit;
  logic      issue0;
  logic      unused_adr;

  assign req    = wbs_stb_i & wbs_cyc_i;
  assign hit    = (wbs_adr_i[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]);
  assign issue0 = (p0_state == IDLE) & req & hit;

  assign sram_csb0   = ~issue0;
  assign sram_web0   = ~(issue0 & wbs_we_i);
  assign sram_wmask0 = wbs_sel_i;
  assign sram_addr0  = wbs_adr_i[ADDR_W+1:2];
  assign sram_din0   = wbs_dat_i;
  assign unused_adr  = &{1'b0, wbs_adr_i[1:0]};

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      p0_state  <= IDLE;
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      case (p0_state)
        IDLE: begin
          wbs_ack_o <= 1'b0;
          if (req) begin
            if (!hit) begin
              // Out-of-window accesses still ack so the master never stalls.
              wbs_dat_o <= MISS_DATA;
              wbs_ack_o <= 1'b1;
              p0_state  <= ACK;
            end else if (wbs_we_i) begin
              wbs_ack_o <= 1'b1;
              p0_state  <= ACK;
            end else begin
              p0_state <= RDWAIT;
            end
          end
        end
        RDWAIT: begin
          wbs_dat_o <= sram_dout0;
          wbs_ack_o <= 1'b1;
          p0_state  <= ACK;
        end
        ACK: begin
          wbs_ack_o <= 1'b0;
          p0_state  <= IDLE;
        end
        default: begin
          wbs_ack_o <= 1'b0;
          p0_state  <= IDLE;
        end
      endcase
    end
  end

  // ---------------- port 1: burst stream reader ----------------
  logic              busy_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   issue_left;
  logic [ADDR_W:0]   pop_left;
  logic              inflight_q;
  logic [1:0]        occ;
  logic [2:0]        used;
  logic              pop;
  logic              start_acc;
  logic              credit_ok;
  logic              issue1;

  assign pop       = rd_valid & rd_ready;
  assign start_acc = rd_start & ~busy_q & (rd_len != '0);

  // A slot freed by this cycle's pop is reusable now; that keeps one word per cycle.
  assign used      = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, pop};
  assign credit_ok = (used < 3'd2);

  // The first word issues in the start cycle itself, straight from rd_base.
  assign issue1     = start_acc | (busy_q & (issue_left != '0) & credit_ok);
  assign sram_csb1  = ~issue1;
  assign sram_addr1 = busy_q ? addr_q : rd_base;
  assign rd_busy    = busy_q;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      busy_q     <= 1'b0;
      addr_q     <= '0;
      issue_left <= '0;
      pop_left   <= '0;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= issue1;
      if (start_acc) begin
        busy_q     <= 1'b1;
        addr_q     <= rd_base + 1'b1;
        issue_left <= rd_len - LEN_ONE;
        pop_left   <= rd_len;
      end else if (busy_q) begin
        if (issue1) begin
          addr_q     <= addr_q + 1'b1;
          issue_left <= issue_left - LEN_ONE;
        end
        if (pop) begin
          pop_left <= pop_left - LEN_ONE;
          if (pop_left == LEN_ONE) begin
            busy_q <= 1'b0;
          end
        end
      end
    end
  end

  stream_fifo2 #(
    .W(DATA_W)
  ) u_fifo (
    .clk       (wb_clk_i),
    .rst       (wb_rst_i),
    .push      (inflight_q),
    .push_data (sram_dout1),
    .pop       (pop),
    .pop_data  (rd_data),
    .valid     (rd_valid),
    .occupancy (occ)
  );

endmodule

// File: tb/tb_wb_sram_ctrl.sv
// tb/tb_wb_sram_ctrl.sv - scoreboard bench for wb_sram_ctrl with a behavioural 1RW1R macro
module tb_wb_sram_ctrl;

  logic        clk;
  logic        rst;
  logic        stb, cyc, we;
  logic [3:0]  sel;
  logic [31:0] dat_i, adr;
  logic        ack;
  logic [31:0] dat_o;
  logic        csb0, web0, csb1;
  logic [3:0]  wmask0;
  logic [7:0]  addr0, addr1;
  logic [31:0] din0, dout0, dout1;
  logic        rd_start, rd_valid, rd_ready, rd_busy;
  logic [7:0]  rd_base;
  logic [8:0]  rd_len;
  logic [31:0] rd_data;

  typedef struct {
    logic [31:0] dat;
    int          cyc;
    bit          chk_dat;
  } wb_exp_t;

  wb_exp_t     wb_q[$];
  logic [31:0] s_q[$];
  logic [31:0] mem [256];

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc_cnt  = 0;
  bit          first_pend = 0;
  int          first_cyc  = 0;
  bit          stall_q    = 0;
  logic [31:0] stall_data = '0;

  wb_sram_ctrl dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .wbs_stb_i  (stb),
    .wbs_cyc_i  (cyc),
    .wbs_we_i   (we),
    .wbs_sel_i  (sel),
    .wbs_dat_i  (dat_i),
    .wbs_adr_i  (adr),
    .wbs_ack_o  (ack),
    .wbs_dat_o  (dat_o),
    .sram_csb0  (csb0),
    .sram_web0  (web0),
    .sram_wmask0(wmask0),
    .sram_addr0 (addr0),
    .sram_din0  (din0),
    .sram_dout0 (dout0),
    .sram_csb1  (csb1),
    .sram_addr1 (addr1),
    .sram_dout1 (dout1),
    .rd_start   (rd_start),
    .rd_base    (rd_base),
    .rd_len     (rd_len),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .rd_busy    (rd_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  always @(posedge clk) begin
    if (!csb0) begin
      if (!web0) begin
        for (int b = 0; b < 4; b++)
          if (wmask0[b]) mem[addr0][b*8 +: 8] <= din0[b*8 +: 8];
      end else begin
        dout0 <= mem[addr0];
      end
    end
    if (!csb1) dout1 <= mem[addr1];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboards whenever the DUT presents a response.
  always @(negedge clk) begin
    wb_exp_t e;
    logic [31:0] s;
    if (rst) begin
      stall_q = 0;
    end else begin
      if (ack) begin
        if (wb_q.size() == 0) begin
          check("unexpected_ack", 32'd1, 32'd0);
        end else begin
          e = wb_q.pop_front();
          check("ack_cycle", cyc_cnt, e.cyc);
          if (e.chk_dat) check("wb_dat_o", dat_o, e.dat);
        end
      end
      if (stall_q) begin
        check("stall_valid_hold", {31'd0, rd_valid}, 32'd1);
        check("stall_data_hold", rd_data, stall_data);
      end
      if (first_pend && rd_valid) begin
        check("first_valid_cycle", cyc_cnt, first_cyc);
        first_pend = 0;
      end
      if (rd_valid && rd_ready) begin
        if (s_q.size() == 0) begin
          check("unexpected_beat", rd_data, 32'hxxxx_xxxx);
        end else begin
          s = s_q.pop_front();
          check("stream_beat", rd_data, s);
        end
      end
      stall_q    = rd_valid && !rd_ready;
      stall_data = rd_data;
    end
  end

  task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [3:0] s,
                         input logic [31:0] d, input logic [31:0] exp_d, input bit chk,
                         input int lat, input logic exp_csb);
    bit got;
    @(posedge clk); #1;
    stb = 1; cyc = 1; we = w; adr = a; sel = s; dat_i = d;
    wb_q.push_back('{exp_d, cyc_cnt + lat, chk});
    #1 check("csb0_on_request", {31'd0, csb0}, {31'd0, exp_csb});
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (ack) got = 1;
    end
    if (!got) check("ack_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    stb = 0; cyc = 0; we = 0;
  endtask

  task automatic stream_run(input logic [7:0] base, input logic [8:0] len, input bit rand_ready);
    int n;
    @(posedge clk); #1;
    rd_ready = 1; rd_start = 1; rd_base = base; rd_len = len;
    first_cyc = cyc_cnt + 2; first_pend = 1;
    n = 0;
    do begin
      @(posedge clk); #1;
      rd_start = 0;
      n++;
      if (rand_ready) rd_ready = 1'($urandom_range(0, 1));
      if (rand_ready && n == 3) begin
        rd_start = 1; rd_base = 8'd5; rd_len = 9'd3;
      end
    end while (rd_busy && n < 300);
    rd_ready = 1;
    check("burst_done_in_time", {31'd0, rd_busy}, 32'd0);
    check("rd_valid_after_burst", {31'd0, rd_valid}, 32'd0);
    check("stream_queue_drained", s_q.size(), 32'd0);
  endtask

  task automatic check_reset_vals();
    check("rst_ack", {31'd0, ack}, 32'd0);
    check("rst_dat_o", dat_o, 32'd0);
    check("rst_csb0", {31'd0, csb0}, 32'd1);
    check("rst_web0", {31'd0, web0}, 32'd1);
    check("rst_csb1", {31'd0, csb1}, 32'd1);
    check("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    check("rst_rd_busy", {31'd0, rd_busy}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    rst = 1; stb = 0; cyc = 0; we = 0; sel = 0; dat_i = 0; adr = 0;
    rd_start = 0; rd_base = 0; rd_len = 0; rd_ready = 1;
    repeat (3) @(posedge clk);
    #1 check_reset_vals();
    rst = 0;

    // Full-word write then read-back.
    wb_xfer(1, 32'h3000_0010, 4'hF, 32'hA5A5_1234, 32'h0, 0, 1, 0);
    wb_xfer(0, 32'h3000_0010, 4'hF, 32'h0, 32'hA5A5_1234, 1, 2, 0);

    // Byte-lane write over zero.
    wb_xfer(1, 32'h3000_0024, 4'hF, 32'h0, 32'h0, 0, 1, 0);
    wb_xfer(1, 32'h3000_0024, 4'b0010, 32'hFFFF_FFFF, 32'h0, 0, 1, 0);
    wb_xfer(0, 32'h3000_0024, 4'hF, 32'h0, 32'h0000_FF00, 1, 2, 0);

    // Out-of-window read and write.
    wb_xfer(0, 32'h2000_0000, 4'hF, 32'h0, 32'h0, 1, 1, 1);
    wb_xfer(1, 32'h2000_0004, 4'hF, 32'h1234_5678, 32'h0, 1, 1, 1);

    // Preload 0..7 and stream them at full rate.
    for (int i = 0; i < 8; i++)
      wb_xfer(1, 32'h3000_0000 + 32'(i * 4), 4'hF, 32'(100 + i), 32'h0, 0, 1, 0);
    for (int i = 0; i < 8; i++) s_q.push_back(32'(100 + i));
    stream_run(8'd0, 9'd8, 0);

    // Wrapping burst with random backpressure and an ignored mid-burst start.
    wb_xfer(1, 32'h3000_03F8, 4'hF, 32'd200, 32'h0, 0, 1, 0);
    wb_xfer(1, 32'h3000_03FC, 4'hF, 32'd201, 32'h0, 0, 1, 0);
    s_q.push_back(32'd200); s_q.push_back(32'd201);
    s_q.push_back(32'd100); s_q.push_back(32'd101);
    stream_run(8'd254, 9'd4, 1);

    // Reset during a burst and a pending Wishbone read.
    for (int i = 0; i < 8; i++) s_q.push_back(32'(100 + i));
    @(posedge clk); #1;
    rd_ready = 1; rd_start = 1; rd_base = 8'd0; rd_len = 9'd8;
    first_cyc = cyc_cnt + 2; first_pend = 1;
    @(posedge clk); #1;
    rd_start = 0;
    stb = 1; cyc = 1; we = 0; adr = 32'h3000_0008; sel = 4'hF;
    @(posedge clk); #1;
    stb = 0; cyc = 0;
    rst = 1;
    #1 check_reset_vals();
    s_q.delete();
    wb_q.delete();
    first_pend = 0;
    @(posedge clk); #1;
    rst = 0;

    // Normal operation after reset release.
    for (int i = 2; i < 5; i++) s_q.push_back(32'(100 + i));
    stream_run(8'd2, 9'd3, 0);
    wb_xfer(0, 32'h3000_0010, 4'hF, 32'h0, 32'd104, 1, 2, 0);

    repeat (3) @(posedge clk);
    check("wb_queue_drained", wb_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/wb_sram_ctrl.md
# wb_sram_ctrl

Wishbone slave controller that sits directly upstream of the `sky130_sram_1kbyte_1rw1r_32x256_8` macro (32 x 256, 1RW + 1R) in the user project wrapper. Port 0 serves Caravel management-core Wishbone reads and writes with correct macro latency and a proper `wbs_ack_o`. Port 1 drives a burst streaming reader that delivers consecutive words to the downstream spectrometer datapath over a valid/ready interface.

## Interface
Parameters:
- `DATA_W`, 32, macro word width
- `ADDR_W`, 8, macro word-address width
- `BASE_ADDR`, 32'h3000_0000, Wishbone window base; hit when `wbs_adr_i[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]`

Ports (single clock `wb_clk_i`; reset `wb_rst_i` is asynchronous, active-high):
- `wb_clk_i` in 1 system clock; also drives `clk0`/`clk1` of the macro
- `wb_rst_i` in 1 async active-high reset
- `wbs_stb_i`, `wbs_cyc_i`, `wbs_we_i` in 1 each Wishbone strobe/cycle/write
- `wbs_sel_i` in 4 byte enables
- `wbs_dat_i` in 32 write data
- `wbs_adr_i` in 32 byte address; word address = `[ADDR_W+1:2]`
- `wbs_ack_o` out 1 acknowledge, registered
- `wbs_dat_o` out 32 read data, registered
- `sram_csb0`, `sram_web0` out 1 each port-0 active-low select/write
- `sram_wmask0` out 4 port-0 write mask
- `sram_addr0` out ADDR_W port-0 address
- `sram_din0` out DATA_W port-0 write data
- `sram_dout0` in DATA_W port-0 read data
- `sram_csb1` out 1 port-1 active-low select
- `sram_addr1` out ADDR_W port-1 address
- `sram_dout1` in DATA_W port-1 read data
- `rd_start` in 1 one-cycle burst start pulse
- `rd_base` in ADDR_W first word address of the burst
- `rd_len` in ADDR_W+1 word count, 1..256
- `rd_data` out DATA_W stream data
- `rd_valid` out 1 stream valid
- `rd_ready` in 1 stream ready from the consumer
- `rd_busy` out 1 high from accepted start until the last word is transferred

## Operation
- Port-0 FSM states: IDLE, RDWAIT, ACK.
- IDLE + `stb&cyc` + hit + `we`: drive `csb0=0`, `web0=0`, `wmask0=sel`, `addr0`, `din0` combinationally; go to ACK.
- IDLE + `stb&cyc` + hit + `!we`: drive `csb0=0`, `web0=1`; go to RDWAIT. RDWAIT: register `sram_dout0` into `wbs_dat_o`; go to ACK.
- Miss: no macro access; go to ACK with `wbs_dat_o=0`, so the bus never hangs.
- ACK: `wbs_ack_o=1` for exactly one cycle, then IDLE. A request is not re-accepted in the ACK cycle.
- `csb0=1`, `web0=1` in every non-issuing cycle.
- Streaming reader: `rd_start` while `!rd_busy` latches `rd_base` and `rd_len` and sets `rd_busy`. `rd_start` while busy is ignored. `rd_len==0` is ignored.
- Uses a 2-entry output FIFO. A port-1 read issues only when FIFO occupancy plus in-flight reads is less than 2 and the issued count is less than `rd_len`.
- Data returns one cycle after issue and is pushed into the FIFO.
- Address increments modulo 256, so 255 wraps to 0.
- `rd_busy` clears in the cycle after the final `rd_valid&rd_ready`.
- Ports are independent. Simultaneous port-0 write and port-1 read to the same address: the port-1 data is undefined, as in the macro, and the bench does not check it.

## Timing
- Reset values: `wbs_ack_o=0`, `wbs_dat_o=0`, `csb0=csb1=1`, `web0=1`, `rd_valid=0`, `rd_busy=0`. The FIFO and counters are cleared.
- Reset mid-burst aborts the burst. Reset mid-transaction drops the ack.
- Write ack latency: 1 cycle after the request cycle. Read ack latency: 2 cycles.
- Miss ack latency: 1 cycle.
- Stream: first `rd_valid` 2 cycles after `rd_start`. Sustains 1 word/cycle with `rd_ready` held high.
- `rd_data` and `rd_valid` hold stable while `rd_valid & !rd_ready`.

## Structure
- Package `sram_ctrl_pkg` holds the port-0 state enum (IDLE/RDWAIT/ACK), `DATA_W`, `ADDR_W`, and the miss data constant 32'h0.
- One sub-module, `stream_fifo2`: a 2-entry FIFO with occupancy output used for the in-flight credit check.

## Test plan
- Write 32'hA5A5_1234 to 0x3000_0010 with `sel=4'hF`, then read it back: ack 1 cycle after the write request, ack 2 cycles after the read request, `wbs_dat_o=32'hA5A5_1234`.
- Write with `sel=4'b0010`, data 32'hFFFF_FFFF, over 0: a read returns 32'h0000_FF00.
- Access to 0x2000_0000: ack after 1 cycle, `dat_o=0`, `csb0` stays 1.
- Preload words 0..7 with 100..107; start with `rd_base=0`, `rd_len=8`, `rd_ready=1`: 8 consecutive beats 100..107, first `rd_valid` 2 cycles after start, `rd_busy` low afterwards.
- Start with `rd_base=254`, `rd_len=4` and random `rd_ready`: addresses 254, 255, 0, 1 are delivered in order with no loss or duplication; `rd_start` pulsed mid-burst is ignored.
- Assert `wb_rst_i` mid-burst and mid-read: all outputs return to their reset values immediately, and a new burst after release behaves normally.
